// File: rtl/multicycle_control.sv
// Main control FSM for a multicycle MIPS-style datapath, with Moore control decode and a retired-instruction counter.
// Define MEM_READY_EN to make FETCH, MEM_RD and MEM_WR wait on the mem_ready handshake.
module multicycle_control #(
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_eq,
  output logic               pc_write_ne,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         aluop,
  output logic [1:0]         pc_source,
  output logic [3:0]         state,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [COUNT_W-1:0] instr_count
);

  localparam int unsigned STATE_W = 4;

  localparam logic [STATE_W-1:0] FETCH    = 4'd0;
  localparam logic [STATE_W-1:0] DECODE   = 4'd1;
  localparam logic [STATE_W-1:0] MEM_ADDR = 4'd2;
  localparam logic [STATE_W-1:0] MEM_RD   = 4'd3;
  localparam logic [STATE_W-1:0] MEM_WB   = 4'd4;
  localparam logic [STATE_W-1:0] MEM_WR   = 4'd5;
  localparam logic [STATE_W-1:0] R_EXEC   = 4'd6;
  localparam logic [STATE_W-1:0] R_WB     = 4'd7;
  localparam logic [STATE_W-1:0] BRANCH   = 4'd8;
  localparam logic [STATE_W-1:0] JUMP     = 4'd9;
  localparam logic [STATE_W-1:0] I_EXEC   = 4'd10;
  localparam logic [STATE_W-1:0] I_WB     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [COUNT_W-1:0] count_q;
  logic               retire_c;
  logic               mem_ok;

  // Memory-side completion: tied high when the handshake is compiled out.
`ifdef MEM_READY_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok           = 1'b1;
`endif

  assign state       = state_q;
  assign instr_count = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire_c) begin
        count_q <= count_q + COUNT_W'(1);
      end
    end
  end

  // Next-state and Moore control decode; rst masks every strobe last.
  always_comb begin
    state_d     = state_q;
    retire_c    = 1'b0;
    pc_write    = 1'b0;
    pc_write_eq = 1'b0;
    pc_write_ne = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    aluop       = 2'b00;
    pc_source   = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;

    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ok;
        pc_write  = mem_ok;
        if (mem_ok) begin
          state_d = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW:   state_d = MEM_ADDR;
          OP_RTYPE:       state_d = R_EXEC;
          OP_BEQ, OP_BNE: state_d = BRANCH;
          OP_J:           state_d = JUMP;
          OP_ADDI:        state_d = I_EXEC;
          default: begin
            state_d    = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ok) begin
          state_d = MEM_WB;
        end
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire_c   = 1'b1;
        state_d    = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ok) begin
          retire_c = 1'b1;
          state_d  = FETCH;
        end
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        aluop     = 2'b10;
        state_d   = R_WB;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire_c  = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a   = 1'b1;
        aluop       = 2'b01;
        pc_source   = 2'b01;
        pc_write_eq = (opcode == OP_BEQ);
        pc_write_ne = (opcode == OP_BNE);
        retire_c    = 1'b1;
        state_d     = FETCH;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire_c  = 1'b1;
        state_d   = FETCH;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = I_WB;
      end
      I_WB: begin
        reg_write = 1'b1;
        retire_c  = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase

    instr_done = retire_c;

    if (rst) begin
      pc_write    = 1'b0;
      pc_write_eq = 1'b0;
      pc_write_ne = 1'b0;
      iord        = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_dst     = 1'b0;
      reg_write   = 1'b0;
      mem_to_reg  = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      aluop       = 2'b00;
      pc_source   = 2'b00;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios plus random instruction streams checked against a step-list model.
// Two instances share stimulus: the default counter width and a 4-bit one that wraps.
module tb_multicycle_control;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;

  logic        pc_write, pc_write_eq, pc_write_ne, iord, mem_read, mem_write, ir_write;
  logic        reg_dst, reg_write, mem_to_reg, alu_src_a, instr_done, illegal_op;
  logic [1:0]  alu_src_b, aluop, pc_source;
  logic [3:0]  state;
  logic [31:0] instr_count;

  logic        pc_write4, pc_write_eq4, pc_write_ne4, iord4, mem_read4, mem_write4, ir_write4;
  logic        reg_dst4, reg_write4, mem_to_reg4, alu_src_a4, instr_done4, illegal_op4;
  logic [1:0]  alu_src_b4, aluop4, pc_source4;
  logic [3:0]  state4;
  logic [3:0]  instr_count4;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_eq(pc_write_eq), .pc_write_ne(pc_write_ne),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .aluop(aluop), .pc_source(pc_source), .state(state),
    .instr_done(instr_done), .illegal_op(illegal_op), .instr_count(instr_count)
  );

  multicycle_control #(.COUNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write4), .pc_write_eq(pc_write_eq4), .pc_write_ne(pc_write_ne4),
    .iord(iord4), .mem_read(mem_read4), .mem_write(mem_write4), .ir_write(ir_write4),
    .reg_dst(reg_dst4), .reg_write(reg_write4), .mem_to_reg(mem_to_reg4), .alu_src_a(alu_src_a4),
    .alu_src_b(alu_src_b4), .aluop(aluop4), .pc_source(pc_source4), .state(state4),
    .instr_done(instr_done4), .illegal_op(illegal_op4), .instr_count(instr_count4)
  );

  logic [18:0] act_ctrl, act_ctrl4;
  assign act_ctrl  = {pc_write, pc_write_eq, pc_write_ne, iord, mem_read, mem_write, ir_write,
                      reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b, aluop, pc_source,
                      instr_done, illegal_op};
  assign act_ctrl4 = {pc_write4, pc_write_eq4, pc_write_ne4, iord4, mem_read4, mem_write4, ir_write4,
                      reg_dst4, reg_write4, mem_to_reg4, alu_src_a4, alu_src_b4, aluop4, pc_source4,
                      instr_done4, illegal_op4};

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model: current state number, the states still to visit for this instruction, retired count.
  int          m_state = 0;
  int          seq[$];
  int unsigned m_cnt   = 0;
  bit          m_known = 0;

  // Observations of the most recent cycle, for directed literal checks.
  int   obs_state;
  logic obs_rw, obs_done, obs_ill, obs_eq, obs_ne, obs_mw;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit mem_ok();
    bit ok = 1'b1;
`ifdef MEM_READY_EN
    ok = mem_ready;
`endif
    return ok;
  endfunction

  // States an instruction visits after DECODE; empty means illegal.
  task automatic load_route(input logic [5:0] op);
    seq.delete();
    case (op)
      OP_LW:          seq = '{2, 3, 4};
      OP_SW:          seq = '{2, 5};
      OP_R:           seq = '{6, 7};
      OP_BEQ, OP_BNE: seq = '{8};
      OP_J:           seq = '{9};
      OP_ADDI:        seq = '{10, 11};
      default:        seq.delete();
    endcase
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {OP_LW, OP_SW, OP_R, OP_BEQ, OP_BNE, OP_J, OP_ADDI};
  endfunction

  function automatic logic [18:0] exp_ctrl();
    logic pcw, eq, ne, io, mr, mw, irw, rd, rw, m2r, asa, done, ill;
    logic [1:0] asb, aop, psrc;
    bit ok;
    ok = mem_ok();
    {pcw, eq, ne, io, mr, mw, irw, rd, rw, m2r, asa, done, ill} = '0;
    asb = 2'd0; aop = 2'd0; psrc = 2'd0;
    case (m_state)
      0:       begin mr = 1; asb = 2'd1; irw = ok; pcw = ok; end
      1:       begin asb = 2'd3; ill = !is_legal(opcode); end
      2, 10:   begin asa = 1; asb = 2'd2; end
      3:       begin mr = 1; io = 1; end
      4:       begin rw = 1; m2r = 1; end
      5:       begin mw = 1; io = 1; end
      6:       begin asa = 1; aop = 2'd2; end
      7:       begin rw = 1; rd = 1; end
      8:       begin asa = 1; aop = 2'd1; psrc = 2'd1; eq = (opcode == OP_BEQ); ne = (opcode == OP_BNE); end
      9:       begin pcw = 1; psrc = 2'd2; end
      11:      begin rw = 1; end
      default: ;
    endcase
    done = (m_state >= 2) && (seq.size() == 0) && (m_state != 5 || ok);
    if (rst) return '0;
    return {pcw, eq, ne, io, mr, mw, irw, rd, rw, m2r, asa, asb, aop, psrc, done, ill};
  endfunction

  task automatic model_step();
    bit hold = 1'b0;
    if (m_state == 0 || m_state == 3 || m_state == 5) hold = !mem_ok();
    if (rst) begin
      m_state = 0;
      m_cnt   = 0;
      m_known = 1;
      seq.delete();
    end else if (!hold) begin
      if (m_state == 0) begin
        m_state = 1;
      end else if (m_state == 1) begin
        load_route(opcode);
        if (seq.size() == 0) m_state = 0;
        else m_state = seq.pop_front();
      end else if (seq.size() == 0) begin
        m_state = 0;
        m_cnt++;
      end else begin
        m_state = seq.pop_front();
      end
    end
  endtask

  // One clock cycle: drive, compare against the model, then advance the model at the edge.
  task automatic cyc(input logic r, input logic [5:0] op, input logic rdy);
    logic [18:0] e;
    @(negedge clk);
    rst = r; opcode = op; mem_ready = rdy;
    #1;
    e = exp_ctrl();
    chk("ctrl", 32'(act_ctrl), 32'(e));
    chk("ctrl_w4", 32'(act_ctrl4), 32'(e));
    if (m_known) begin
      chk("state", 32'(state), 32'(m_state));
      chk("state_w4", 32'(state4), 32'(m_state));
      chk("count", instr_count, m_cnt);
      chk("count_w4", 32'(instr_count4), m_cnt & 32'hF);
    end
    obs_state = int'(state);
    obs_rw = reg_write; obs_done = instr_done; obs_ill = illegal_op;
    obs_eq = pc_write_eq; obs_ne = pc_write_ne; obs_mw = mem_write;
    @(posedge clk);
    model_step();
  endtask

  int lw_exp[5]  = '{0, 1, 2, 3, 4};
  int bne_exp[3] = '{0, 1, 8};

  initial begin
    int n_rw, rw_st, n_done, done_idx, n_ill, n_mw;
    logic [5:0] cur_op;
    rst = 1'b1; opcode = 6'd0; mem_ready = 1'b1;

    // Reset for two cycles
    cyc(1, 6'd0, 1);
    cyc(1, 6'd0, 1);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count", instr_count, 32'd0);

    // lw: 0,1,2,3,4 then back to 0
    n_rw = 0; rw_st = -1;
    for (int i = 0; i < 5; i++) begin
      cyc(0, OP_LW, 1);
      chk("lw_seq", 32'(obs_state), 32'(lw_exp[i]));
      if (obs_rw) begin n_rw++; rw_st = obs_state; end
    end
    #1;
    chk("lw_rw_cycles", 32'(n_rw), 32'd1);
    chk("lw_rw_state", 32'(rw_st), 32'd4);
    chk("lw_end_state", 32'(state), 32'd0);
    chk("lw_count", instr_count, 32'd1);

    // bne: 0,1,8 with pc_write_ne in BRANCH
    n_done = 0; done_idx = -1;
    for (int i = 0; i < 3; i++) begin
      cyc(0, OP_BNE, 1);
      chk("bne_seq", 32'(obs_state), 32'(bne_exp[i]));
      if (obs_done) begin n_done++; done_idx = i; end
      if (i == 2) begin
        chk("bne_ne", 32'(obs_ne), 32'd1);
        chk("bne_eq", 32'(obs_eq), 32'd0);
      end
    end
    #1;
    chk("bne_done_cycles", 32'(n_done), 32'd1);
    chk("bne_done_idx", 32'(done_idx), 32'd2);
    chk("bne_count", instr_count, 32'd2);

    // Illegal opcode: 0,1 then FETCH, count unchanged
    n_ill = 0;
    for (int i = 0; i < 2; i++) begin
      cyc(0, 6'b111111, 1);
      chk("ill_seq", 32'(obs_state), 32'(i));
      if (obs_ill) n_ill++;
    end
    #1;
    chk("ill_pulses", 32'(n_ill), 32'd1);
    chk("ill_state", 32'(state), 32'd0);
    chk("ill_count", instr_count, 32'd2);

    // Reset landing in R_EXEC abandons the instruction
    n_rw = 0; n_done = 0;
    cyc(0, OP_R, 1);
    cyc(0, OP_R, 1);
    cyc(1, OP_R, 1);
    chk("rrst_state_at_rst", 32'(obs_state), 32'd6);
    cyc(0, OP_R, 1);
    if (obs_rw) n_rw++;
    if (obs_done) n_done++;
    chk("rrst_next_state", 32'(obs_state), 32'd0);
    chk("rrst_rw", 32'(n_rw), 32'd0);
    chk("rrst_done", 32'(n_done), 32'd0);
    chk("rrst_count", instr_count, 32'd0);

    // Finish R-type from FETCH already consumed above, then 16 jumps
    cyc(0, OP_R, 1);
    cyc(0, OP_R, 1);
    cyc(0, OP_R, 1);
    cyc(1, OP_R, 1);
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 3; i++) cyc(0, OP_J, 1);
      if (k == 14) begin
        #1;
        chk("j_w4_at15", 32'(instr_count4), 32'd15);
      end
    end
    #1;
    chk("j_w4_wrap", 32'(instr_count4), 32'd0);
    chk("j_count", instr_count, 32'd16);

`ifdef MEM_READY_EN
    // sw with three not-ready cycles in MEM_WR
    n_mw = 0; n_done = 0; done_idx = -1;
    cyc(0, OP_SW, 1);
    cyc(0, OP_SW, 1);
    cyc(0, OP_SW, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, OP_SW, (i == 3));
      if (obs_mw) n_mw++;
      if (obs_done) begin n_done++; done_idx = i; end
    end
    #1;
    chk("sw_mw_cycles", 32'(n_mw), 32'd4);
    chk("sw_done_cycles", 32'(n_done), 32'd1);
    chk("sw_done_idx", 32'(done_idx), 32'd3);
    chk("sw_count", instr_count, 32'd17);
`else
    n_mw = 0;
    if (n_mw != 0) errors++;
`endif

    // Random instruction stream with occasional resets and mem_ready noise
    cur_op = OP_LW;
    for (int c = 0; c < 4000; c++) begin
      logic r, rdy;
      int pick;
      r   = ($urandom_range(0, 99) < 2);
      rdy = ($urandom_range(0, 3) != 0);
      if (m_state == 0) begin
        pick = int'($urandom_range(0, 8));
        case (pick)
          0: cur_op = OP_LW;
          1: cur_op = OP_SW;
          2: cur_op = OP_R;
          3: cur_op = OP_BEQ;
          4: cur_op = OP_BNE;
          5: cur_op = OP_J;
          6: cur_op = OP_ADDI;
          default: cur_op = 6'($urandom);
        endcase
      end
      cyc(r, cur_op, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter COUNT_W, default 32, setting the width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates SHALL occur on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 opcode  input  6  instruction[31:26] from the instruction register.
REQ-005 mem_ready  input  1  memory completion handshake, used only under REQ-027.
REQ-006 pc_write, pc_write_eq, pc_write_ne  output  1 each  unconditional PC load, PC load if zero, PC load if not zero.
REQ-007 iord, mem_read, mem_write, ir_write  output  1 each  memory address select (0 = PC, 1 = ALUOut), memory strobes, IR load.
REQ-008 reg_dst, reg_write, mem_to_reg, alu_src_a  output  1 each  register-file and ALU operand selects.
REQ-009 alu_src_b  output  2, aluop  output  2, pc_source  output  2  ALU B select, ALU op class, next-PC select.
REQ-010 state  output  4  current FSM state encoding.
REQ-011 instr_done  output  1  one-cycle pulse on the final cycle of each instruction.
REQ-012 illegal_op  output  1  one-cycle pulse when DECODE sees an unsupported opcode.
REQ-013 instr_count  output  COUNT_W  count of retired instructions.

Function
REQ-014 The FSM SHALL use these states: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11.
REQ-015 Outputs SHALL be Moore, decoded from state only, except for the mem_ready gating in REQ-027.
- Any signal not listed for a state SHALL be 0.
REQ-016 FETCH SHALL assert mem_read, ir_write, alu_src_b=01, aluop=00, pc_write and pc_source=00, and SHALL go to DECODE.
REQ-017 DECODE SHALL assert alu_src_b=11 and aluop=00, then dispatch on opcode:
- 100011 (lw) / 101011 (sw) -> MEM_ADDR
- 000000 -> R_EXEC
- 000100 / 000101 -> BRANCH
- 000010 -> JUMP
- 001000 (addi) -> I_EXEC
- any other opcode -> FETCH, with illegal_op=1 for that cycle.
REQ-018 MEM_ADDR SHALL assert alu_src_a=1, alu_src_b=10, aluop=00, and SHALL go to MEM_RD for lw or MEM_WR for sw.
REQ-019 MEM_RD SHALL assert mem_read and iord and SHALL go to MEM_WB.
REQ-020 MEM_WB SHALL assert reg_write and mem_to_reg, with reg_dst=0.
REQ-021 MEM_WR SHALL assert mem_write and iord.
REQ-022 R_EXEC SHALL assert alu_src_a=1, alu_src_b=00, aluop=10.
- R_WB SHALL assert reg_write and reg_dst=1.
REQ-023 I_EXEC SHALL assert alu_src_a=1, alu_src_b=10, aluop=00.
- I_WB SHALL assert reg_write with reg_dst=0.
REQ-024 BRANCH SHALL assert alu_src_a=1, alu_src_b=00, aluop=01, pc_source=01.
- It SHALL assert pc_write_eq for opcode 000100 and pc_write_ne for opcode 000101.
REQ-025 JUMP SHALL assert pc_write and pc_source=10.
REQ-026 Terminal states SHALL assert instr_done and SHALL return to FETCH.
- Terminal states are MEM_WB, MEM_WR, R_WB, I_WB, BRANCH and JUMP.
- instr_count SHALL increment by 1 in that cycle.
- instr_count SHALL wrap from all-ones to 0.
- An illegal opcode SHALL NOT increment instr_count.
- Latencies: lw 5 cycles; sw, R-type and addi 4 cycles; beq, bne and j 3 cycles.

Configuration
REQ-027 Macro MEM_READY_EN SHALL control the memory handshake.
- When defined: FETCH, MEM_RD and MEM_WR SHALL hold while mem_ready=0, keeping mem_read/mem_write asserted.
- When defined: in FETCH, ir_write and pc_write SHALL assert only in the cycle mem_ready=1.
- When defined: MEM_WR SHALL assert instr_done and increment instr_count only in the cycle mem_ready=1.
- When undefined: mem_ready SHALL be ignored and every state SHALL last exactly one cycle.

Reset
REQ-028 While rst=1 at a rising edge, state SHALL load FETCH and instr_count SHALL load 0.
REQ-029 While rst=1, all control outputs, instr_done and illegal_op SHALL be forced to 0.
REQ-030 Reset SHALL override every transition and any pending mem_ready wait.
- The first cycle after rst falls SHALL be FETCH.
REQ-031 An rst pulse mid-instruction SHALL abandon that instruction without asserting reg_write, mem_write or instr_done.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- rst=1 for 2 cycles, then opcode=100011 -> state 0,1,2,3,4,0; reg_write=1 only in state 4; instr_count=1.
- opcode=000101 -> state 0,1,8,0; pc_write_ne=1 and pc_write_eq=0 in state 8; instr_done in cycle 3.
- opcode=111111 -> state 0,1,0; illegal_op pulses once in DECODE; instr_count unchanged.
- MEM_READY_EN defined, sw with mem_ready low for 3 cycles in MEM_WR -> mem_write held 4 cycles; instr_done only on the ready cycle.
- rst asserted in R_EXEC -> next state 0; reg_write never asserted; instr_count=0.
- COUNT_W=4, 16 j instructions -> instr_count wraps 15 -> 0.
